// File: rtl/command_scheduler.sv
// Command scheduler: assembles 3-byte UART commands into a FIFO and sequences
// each through an executor start/done handshake and an acknowledge handshake.
module command_scheduler #(
   parameter int DEPTH      = 4,
   parameter int GAP_CYCLES = 1024,
   parameter int TIMEOUT    = 2**30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic [7:0] lmotor,
   output logic [7:0] rmotor,
   output logic [7:0] dur,
   output logic       exec_start,
   input  logic       exec_done,
   output logic       ack_req,
   input  logic       ack_sent,
   output logic       fault,
   output logic       cmd_dropped,
   output logic [3:0] fifo_count,
   output logic       busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_ACK   = 3'd4;

   logic [2:0]    state;
   logic [1:0]    idx;
   logic [7:0]    b0, b1;
   logic [GW-1:0] gap_cnt;
   logic [WW-1:0] wd_cnt;
   logic [23:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [3:0]    count;
   logic [23:0]   head;
   logic          head_stop, push, pop, full, accept;

   assign full      = (count == 4'(DEPTH));
   assign push      = rx_valid && (idx == 2'd2);
   assign pop       = (state == S_LOAD);
   assign accept    = push && (!full || pop);
   assign head      = mem[rd_ptr];
   assign head_stop = (head[7:0] == 8'd0);

   // Byte assembler; the gap counter clears on expiry, so it can never wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx     <= 2'd0;
         b0      <= 8'd0;
         b1      <= 8'd0;
         gap_cnt <= '0;
      end else if (rx_valid) begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         gap_cnt <= '0;
         case (idx)
            2'd0:    begin b0 <= rx_byte; idx <= 2'd1; end
            2'd1:    begin b1 <= rx_byte; idx <= 2'd2; end
            default: idx <= 2'd0;
         endcase
      end else if (idx != 2'd0) begin
         if (gap_cnt >= GAP_LAST) begin
            idx     <= 2'd0;
            gap_cnt <= '0;
         end else begin
            gap_cnt <= gap_cnt + 1'b1;
         end
      end
   end

   // NOTE: storage array has no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= {b0, b1, rx_byte};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= 4'd0;
         cmd_dropped <= 1'b0;
      end else begin
         cmd_dropped <= push && full && !pop;
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         lmotor <= 8'd0;
         rmotor <= 8'd0;
         dur    <= 8'd0;
         fault  <= 1'b0;
         wd_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: if (count != 4'd0) state <= S_LOAD;
            S_LOAD: begin
               // A zero duration is a stop command: motors off, skip the executor.
               lmotor <= head_stop ? 8'd0 : head[23:16];
               rmotor <= head_stop ? 8'd0 : head[15:8];
               dur    <= head[7:0];
               fault  <= 1'b0;
               state  <= head_stop ? S_ACK : S_START;
            end
            S_START: begin
               wd_cnt <= '0;
               state  <= S_RUN;
            end
            S_RUN: begin
               // wd_cnt==0 marks the first RUN cycle, where exec_done is still stale.
               if (wd_cnt != '0 && exec_done) begin
                  state <= S_ACK;
               end else if (wd_cnt == WD_LAST) begin
                  lmotor <= 8'd0;
                  rmotor <= 8'd0;
                  fault  <= 1'b1;
                  state  <= S_ACK;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            S_ACK:   if (ack_sent) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign exec_start = (state == S_START);
   assign ack_req    = (state == S_ACK);
   assign busy       = (state != S_IDLE);
   assign fifo_count = count;

endmodule
